// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its prefetch FIFO.
package instr_fetch_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Redirect targets are word-aligned by dropping the byte offset.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM and decode-side bus of the fetch controller: ROM word address/data plus the instruction handshake.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [31:0]       instr_pc;
  logic              instr_ready;

  modport master (
    output imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_data, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr_data, instr_pc,
    output imem_data, instr_ready
  );

endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// Prefetch FIFO holding {pc, instruction} entries; flush empties it in one edge and beats push/pop.
module instr_fetch_ctrl_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = cnt;
  // Head reads as zero when empty so the decode side never sees stale entries.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, addresses the combinational ROM and
// prefetches words into a small FIFO toward decode; redirects flush and restart fetching.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 6,
  parameter int          DATA_W     = 32,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  instr_fetch_ctrl_if.master            bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          misalign_err
);

  fetch_state_t          state_q;
  fetch_state_t          state_d;
  logic [31:0]           fetch_pc;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_W+31:0]    head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fetch_en)  state_d = ST_FETCH;
      ST_FETCH: if (!fetch_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A redirect kills the current cycle's push and the FIFO contents, including any pop in flight.
  assign pop  = ~empty & bus.instr_ready;
  assign push = (state_q == ST_FETCH) & fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_INCR;
      end
    end
  end

  instr_fetch_ctrl_fifo #(
    .WIDTH (DATA_W + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   ({fetch_pc, bus.imem_data}),
    .rdata   (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.imem_addr   = fetch_pc[ADDR_W+1:2];
  assign bus.instr_valid = ~empty;
  assign bus.instr_pc    = head[DATA_W+31:DATA_W];
  assign bus.instr_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a combinational ROM where ROM[i] = 32'hA000_0000 + i.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  fifo_count;
  logic        misalign_err;
  int          checks;
  int          errors;

  instr_fetch_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  assign bus.imem_data = 32'hA000_0000 + {26'd0, bus.imem_addr};

  instr_fetch_ctrl #(
    .ADDR_W     (6),
    .DATA_W     (32),
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fifo_count     (fifo_count),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n         = 1'b0;
    fetch_en        = 1'b0;
    bus.instr_ready = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    cycle(1);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    fetch_en        = 1'b0;
    bus.instr_ready = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    cycle(2);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0h expected 0", bus.instr_valid); end
    checks++; if (bus.instr_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_data: got %0h expected 0", bus.instr_data); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %0h expected 0", bus.instr_pc); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_misalign: got %0h expected 0", misalign_err); end
    checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL rst_imem_addr: got %0d expected 0", bus.imem_addr); end
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b1;
    cycle(1);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_enter_fetch_valid: got %0h expected 0", bus.instr_valid); end
    cycle(1);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_first_valid: got %0h expected 1", bus.instr_valid); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL seq_first_pc: got %0h expected 0", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_0000) begin errors++; $display("[TB] FAIL seq_first_data: got %0h expected a0000000", bus.instr_data); end
    for (int i = 1; i <= 4; i++) begin
      cycle(1);
      exp_pc   = 32'(4 * i);
      exp_data = 32'hA000_0000 + 32'(i);
      checks++; if (bus.instr_pc !== exp_pc) begin errors++; $display("[TB] FAIL seq_pc[%0d]: got %0h expected %0h", i, bus.instr_pc, exp_pc); end
      checks++; if (bus.instr_data !== exp_data) begin errors++; $display("[TB] FAIL seq_data[%0d]: got %0h expected %0h", i, bus.instr_data, exp_data); end
      checks++; if (fifo_count !== 2'd1) begin errors++; $display("[TB] FAIL seq_count[%0d]: got %0d expected 1", i, fifo_count); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b0;
    cycle(5);
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("[TB] FAIL bp_count_sat: got %0d expected 2", fifo_count); end
    checks++; if (bus.imem_addr !== 6'd2) begin errors++; $display("[TB] FAIL bp_pc_halt: got %0d expected 2", bus.imem_addr); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head0: got %0h expected 0", bus.instr_pc); end
    bus.instr_ready = 1'b1;
    cycle(1);
    checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("[TB] FAIL bp_head4: got %0h expected 4", bus.instr_pc); end
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("[TB] FAIL bp_full_pop_count: got %0d expected 2", fifo_count); end
    cycle(1);
    checks++; if (bus.instr_pc !== 32'h8) begin errors++; $display("[TB] FAIL bp_head8: got %0h expected 8", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_0002) begin errors++; $display("[TB] FAIL bp_data8: got %0h expected a0000002", bus.instr_data); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b0;
    cycle(3);
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("[TB] FAIL rf_held: got %0d expected 2", fifo_count); end
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h40;
    bus.instr_ready = 1'b1;
    cycle(1);
    redirect_valid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_valid_after_flush: got %0h expected 0", bus.instr_valid); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL rf_count_after_flush: got %0d expected 0", fifo_count); end
    checks++; if (bus.imem_addr !== 6'h10) begin errors++; $display("[TB] FAIL rf_imem_addr: got %0h expected 10", bus.imem_addr); end
    cycle(1);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL rf_target_valid: got %0h expected 1", bus.instr_valid); end
    checks++; if (bus.instr_pc !== 32'h40) begin errors++; $display("[TB] FAIL rf_target_pc: got %0h expected 40", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_0010) begin errors++; $display("[TB] FAIL rf_target_data: got %0h expected a0000010", bus.instr_data); end
    cycle(1);
    checks++; if (bus.instr_pc !== 32'h44) begin errors++; $display("[TB] FAIL rf_next_pc: got %0h expected 44", bus.instr_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b1;
    cycle(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFC;
    cycle(1);
    redirect_valid = 1'b0;
    checks++; if (bus.imem_addr !== 6'd63) begin errors++; $display("[TB] FAIL wrap_addr63: got %0d expected 63", bus.imem_addr); end
    cycle(1);
    checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL wrap_addr0: got %0d expected 0", bus.imem_addr); end
    checks++; if (bus.instr_pc !== 32'hFC) begin errors++; $display("[TB] FAIL wrap_pc_fc: got %0h expected fc", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_003F) begin errors++; $display("[TB] FAIL wrap_data_fc: got %0h expected a000003f", bus.instr_data); end
    cycle(1);
    checks++; if (bus.instr_pc !== 32'h100) begin errors++; $display("[TB] FAIL wrap_pc_100: got %0h expected 100", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_0000) begin errors++; $display("[TB] FAIL wrap_data_100: got %0h expected a0000000", bus.instr_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b1;
    cycle(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cycle(1);
    redirect_pc = 32'h30;
    cycle(1);
    redirect_valid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid: got %0h expected 0", bus.instr_valid); end
    cycle(1);
    checks++; if (bus.instr_pc !== 32'h30) begin errors++; $display("[TB] FAIL b2b_pc: got %0h expected 30", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_000C) begin errors++; $display("[TB] FAIL b2b_data: got %0h expected a000000c", bus.instr_data); end
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b1;
    cycle(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    cycle(1);
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_set: got %0h expected 1", misalign_err); end
    checks++; if (bus.imem_addr !== 6'd8) begin errors++; $display("[TB] FAIL mis_addr: got %0d expected 8", bus.imem_addr); end
    cycle(2);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_sticky: got %0h expected 1", misalign_err); end
    checks++; if (bus.instr_pc !== 32'h24) begin errors++; $display("[TB] FAIL mis_pc: got %0h expected 24", bus.instr_pc); end
    reset_n = 1'b0;
    #2;
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL mis_reset_clear: got %0h expected 0", misalign_err); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_reset_valid: got %0h expected 0", bus.instr_valid); end
    checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL mis_reset_pc: got %0h expected 0", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'h0) begin errors++; $display("[TB] FAIL mis_reset_data: got %0h expected 0", bus.instr_data); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("[TB] FAIL mis_reset_count: got %0d expected 0", fifo_count); end
    checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL mis_reset_addr: got %0d expected 0", bus.imem_addr); end
    fetch_en = 1'b0;
    cycle(1);
    reset_n = 1'b1;
  endtask

  task automatic test_drain();
    do_reset();
    fetch_en        = 1'b1;
    bus.instr_ready = 1'b0;
    cycle(3);
    fetch_en        = 1'b0;
    bus.instr_ready = 1'b1;
    cycle(1);
    checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("[TB] FAIL drain_head4: got %0h expected 4", bus.instr_pc); end
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("[TB] FAIL drain_count1: got %0d expected 1", fifo_count); end
    cycle(1);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_valid: got %0h expected 0", bus.instr_valid); end
    checks++; if (bus.instr_data !== 32'h0) begin errors++; $display("[TB] FAIL drain_empty_data: got %0h expected 0", bus.instr_data); end
    cycle(1);
    checks++; if (bus.imem_addr !== 6'd2) begin errors++; $display("[TB] FAIL drain_addr_frozen: got %0d expected 2", bus.imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    cycle(1);
    redirect_valid = 1'b0;
    checks++; if (bus.imem_addr !== 6'h20) begin errors++; $display("[TB] FAIL idle_redir_addr: got %0h expected 20", bus.imem_addr); end
    cycle(1);
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_redir_valid: got %0h expected 0", bus.instr_valid); end
    fetch_en = 1'b1;
    cycle(2);
    checks++; if (bus.instr_pc !== 32'h80) begin errors++; $display("[TB] FAIL idle_resume_pc: got %0h expected 80", bus.instr_pc); end
    checks++; if (bus.instr_data !== 32'hA000_0020) begin errors++; $display("[TB] FAIL idle_resume_data: got %0h expected a0000020", bus.instr_data); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_back_to_back();
    test_misalign();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
